spi_pwm7_driver: RTL and testbench
==================================

Name: spi_pwm7_driver

Overview:
- Seven-channel 8-bit PWM generator configured over an SPI slave interface (mode 0, MSB first).
- Packaged for an 8-in/8-out tile: io_in carries clock, reset and SPI inputs; io_out carries the 7 PWM outputs and MISO.
- The host writes a duty byte per channel. Duties can be read back over the same bus.

Parameters:
- NUM_CH, 7, number of PWM channels (fixed; not overridable).
- PWM_MAX, 254, top count of the PWM counter (period = 255 clk cycles).

Ports:
- io_in[0] (clk), input, 1, system clock, rising-edge.
- io_in[1] (reset), input, 1, asynchronous active-low reset.
- io_in[2] (sclk), input, 1, SPI clock, asynchronous to clk.
- io_in[3] (cs), input, 1, SPI chip select, active-low.
- io_in[4] (mosi), input, 1, SPI data in.
- io_in[7:5], input, 3, unused, ignored.
- io_out[6:0] (pwm_out), output, 7, channel n PWM on bit n.
- io_out[7] (miso), output, 1, SPI data out.

Behaviour:
- Reset (reset=0, async): all duty and shadow registers = 0, PWM counter = 0, io_out = 8'h00, SPI state idle.
- Synchronisation:
  - sclk, cs, mosi pass through 2-FF synchronisers into the clk domain; edges are detected on the synchronised signals.
  - Required ratio: clk ≥ 4× sclk.
- SPI framing:
  - cs low starts a frame and clears the bit counter.
  - mosi is sampled on synchronised sclk rising edges.
  - Frame = 16 bits, MSB first: bit15 = R/W (1 = write, 0 = read), bits14:8 = channel address, bits7:0 = data.
- Write: on the 16th rising edge, if address < 7, data goes to the shadow duty of that channel. Address ≥ 7: ignored.
- Read:
  - On the 8th rising edge, the shadow duty of the addressed channel (0 for address ≥ 7) loads the MISO shift register.
  - miso immediately shows bit7; it shifts on each subsequent sclk falling edge.
  - Bits 7:0 of the second byte of a read frame are ignored.
- miso = 0 when cs high and during the first byte.
- Bits beyond 16 are ignored until cs rises.
- cs rising before the 16th edge aborts the frame: no write, state returns to idle.
- PWM:
  - 8-bit counter runs 0..254 then wraps to 0, every clk.
  - pwm_out[n] = (counter < duty[n]), registered.
  - Duty 0 gives a constant low output; duty 255 gives a constant high output.
  - Active duty[n] loads from shadow[n] only when the counter wraps to 0, so there are no glitches or partial periods.
  - Readback returns the shadow value.
- Reset mid-frame or mid-period returns to the reset state immediately.

Test Plan:
- Reset: hold reset=0 → io_out = 0x00; release reset, run 600 clk → all pwm outputs stay 0.
- Write channel 0 duty 64 (frame 0x8040) → after the next wrap, pwm_out[0] high for exactly 64 of every 255 clk cycles; other channels stay low.
- Write channel 3 duty 255 and channel 1 duty 128 → pwm_out[3] constantly high; pwm_out[1] high 128 of 255 cycles; channel 0 is unaffected.
- Readback: after writing channel 2 = 0xA5, send read frame 0x0200 → MISO bits in the second byte = 1010_0101; read of address 9 → 0x00.
- Abort: raise cs after 10 bits of 0x8560 → channel 5 duty unchanged (0); a next full frame is decoded correctly.
- Mid-period update: change channel 0 duty from 64 to 10 while the counter is at 30 → the current period completes at 64 high cycles; the following period has 10.

Source files
------------

// File: rtl/spi_pwm7_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_pwm7_driver_if
// Description : 8-in/8-out tile pin bundle for the SPI-configured PWM driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_pwm7_driver_if;
    logic [7:0] io_in;
    logic [7:0] io_out;

    modport master (output io_in, input io_out);
    modport slave  (input io_in, output io_out);
endinterface
`default_nettype wire

// File: rtl/spi_pwm7_driver.sv
`default_nettype none
// ============================================================================
// Module      : spi_pwm7_driver
// Description : Seven-channel 8-bit PWM with duty bytes written/read over SPI mode 0.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_pwm7_driver (
    spi_pwm7_driver_if.slave bus
);
    localparam int         NUM_CH  = 7;
    localparam logic [7:0] PWM_MAX = 8'd254;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    logic clk;
    logic rst_n;
    logic unused_io;

    assign clk       = bus.io_in[0];
    assign rst_n     = bus.io_in[1];
    assign unused_io = ^bus.io_in[7:5];

    // ------------------------------------------------------------------
    // Synchronisers; sclk keeps a third stage for edge detection
    // ------------------------------------------------------------------
    logic [2:0] sclk_sync_q;
    logic [1:0] cs_sync_q;
    logic [1:0] mosi_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= 3'b000;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], bus.io_in[2]};
            cs_sync_q   <= {cs_sync_q[0], bus.io_in[3]};
            mosi_sync_q <= {mosi_sync_q[0], bus.io_in[4]};
        end
    end

    logic sclk_rise;
    logic sclk_fall;
    logic cs_n;
    logic mosi_s;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_n      = cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];

    // ------------------------------------------------------------------
    // SPI frame decoder
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic [14:0] shift_q, shift_d;
    logic        rd_en_q, rd_en_d;
    logic [7:0]  miso_sr_q, miso_sr_d;
    logic [7:0]  shadow_q [NUM_CH];

    logic [6:0]  rd_addr;
    logic [7:0]  rd_byte;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;

    assign rd_addr = {shift_q[5:0], mosi_s};

    always_comb begin
        rd_byte = 8'h00;
        if (rd_addr < 7'd7) begin
            rd_byte = shadow_q[rd_addr[2:0]];
        end
    end

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        rd_en_d   = rd_en_q;
        miso_sr_d = miso_sr_q;
        wr_en     = 1'b0;
        wr_addr   = shift_q[9:7];
        wr_data   = {shift_q[6:0], mosi_s};

        case (state_q)
            ST_IDLE: begin
                rd_en_d = 1'b0;
                if (!cs_n) begin
                    state_d  = ST_SHIFT;
                    bitcnt_d = 5'd0;
                end
            end
            ST_SHIFT: begin
                if (cs_n) begin
                    state_d = ST_IDLE;
                    rd_en_d = 1'b0;
                end else if (sclk_rise) begin
                    shift_d  = {shift_q[13:0], mosi_s};
                    bitcnt_d = bitcnt_q + 5'd1;
                    if (bitcnt_q == 5'd7 && !shift_q[6]) begin
                        rd_en_d   = 1'b1;
                        miso_sr_d = rd_byte;
                    end
                    if (bitcnt_q == 5'd15) begin
                        state_d = ST_HOLD;
                        wr_en   = shift_q[14] && (shift_q[13:7] < 7'd7);
                    end
                // The falling edge right after the load belongs to bit7, so
                // shifting only starts once the 9th rising edge has passed.
                end else if (sclk_fall && rd_en_q && bitcnt_q >= 5'd9) begin
                    miso_sr_d = {miso_sr_q[6:0], 1'b0};
                end
            end
            ST_HOLD: begin
                if (cs_n) begin
                    state_d = ST_IDLE;
                    rd_en_d = 1'b0;
                end else if (sclk_fall && rd_en_q) begin
                    miso_sr_d = {miso_sr_q[6:0], 1'b0};
                end
            end
            default: begin
                state_d = ST_IDLE;
                rd_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bitcnt_q  <= 5'd0;
            shift_q   <= 15'd0;
            rd_en_q   <= 1'b0;
            miso_sr_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            rd_en_q   <= rd_en_d;
            miso_sr_q <= miso_sr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= 8'h00;
        end else if (wr_en) begin
            shadow_q[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // PWM core; active duties reload only on counter wrap
    // ------------------------------------------------------------------
    logic [7:0]        cnt_q;
    logic [7:0]        duty_q [NUM_CH];
    logic [NUM_CH-1:0] pwm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
            pwm_q <= '0;
            for (int i = 0; i < NUM_CH; i++) duty_q[i] <= 8'h00;
        end else begin
            cnt_q <= (cnt_q == PWM_MAX) ? 8'd0 : cnt_q + 8'd1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (cnt_q == PWM_MAX) duty_q[i] <= shadow_q[i];
                pwm_q[i] <= (cnt_q < duty_q[i]);
            end
        end
    end

    assign bus.io_out[6:0] = pwm_q;
    assign bus.io_out[7]   = rd_en_q & miso_sr_q[7];

endmodule
`default_nettype wire

// File: tb/tb_spi_pwm7_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_pwm7_driver
// Description : Randomised/directed bench with a behavioural duty/readback model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_pwm7_driver;
    localparam int HALF = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sclk  = 1'b0;
    logic cs    = 1'b1;
    logic mosi  = 1'b0;

    spi_pwm7_driver_if bus ();
    assign bus.io_in = {3'b000, mosi, cs, sclk, rst_n, clk};

    spi_pwm7_driver dut (.bus(bus.slave));

    always #5 clk = ~clk;

    int         shadow_m [7];
    int         hi_cnt [7];
    int         checks = 0;
    int         passes = 0;
    int         fails  = 0;
    logic [7:0] rx;
    logic       first_miso;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_frame(input logic [15:0] w, input int nbits);
        cs = 1'b0; rx = 8'h00; first_miso = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            mosi = w[15-i];
            wait_clk(HALF);
            if (i >= 8) rx[15-i] = bus.io_out[7];
            else        first_miso = first_miso | bus.io_out[7];
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(HALF);
        cs = 1'b1; mosi = 1'b0;
        wait_clk(2*HALF);
    endtask

    task automatic host_write(input logic [6:0] addr, input logic [7:0] data);
        spi_frame({1'b1, addr, data}, 16);
        if (addr < 7) shadow_m[addr] = data;
    endtask

    task automatic host_read(input logic [6:0] addr, input string tag);
        spi_frame({1'b0, addr, 8'h00}, 16);
        check({tag, "_data"}, {24'd0, rx}, (addr < 7) ? shadow_m[addr] : 0);
        check({tag, "_byte0_miso"}, {31'd0, first_miso}, 0);
    endtask

    // Any 255-cycle window of a settled channel holds exactly duty high cycles.
    task automatic check_pwm(input string tag);
        wait_clk(520);
        for (int n = 0; n < 7; n++) hi_cnt[n] = 0;
        repeat (255) begin
            @(negedge clk);
            for (int n = 0; n < 7; n++) hi_cnt[n] += int'(bus.io_out[n]);
        end
        for (int n = 0; n < 7; n++)
            check($sformatf("%s_ch%0d", tag, n), hi_cnt[n], shadow_m[n]);
    endtask

    initial begin
        int  seen;
        int  found;
        int  len;
        int  k;
        logic prev;
        logic [15:0] w;

        for (int n = 0; n < 7; n++) shadow_m[n] = 0;

        // Reset state and idle period
        wait_clk(5);
        check("reset_io_out", {24'd0, bus.io_out}, 0);
        rst_n = 1'b1;
        seen = 0;
        repeat (600) begin
            @(negedge clk);
            if (bus.io_out[6:0] != 7'd0) seen = 1;
        end
        check("idle_pwm_low", seen, 0);

        host_write(7'd0, 8'd64);
        check_pwm("ch0_64");

        host_write(7'd3, 8'd255);
        host_write(7'd1, 8'd128);
        check_pwm("ch3_255_ch1_128");

        host_write(7'd2, 8'hA5);
        host_read(7'd2, "read_ch2");
        host_read(7'd9, "read_addr9");
        check("miso_cs_high", {31'd0, bus.io_out[7]}, 0);

        // Aborted frame leaves channel 5 alone
        spi_frame(16'h8560, 10);
        host_read(7'd5, "abort_ch5");
        host_write(7'd5, 8'h33);
        host_read(7'd5, "after_abort_ch5");

        // Mid-period update of channel 0 from 64 to 10
        wait_clk(520);
        w = 16'h800A;
        cs = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 15; i++) begin
            mosi = w[15-i];
            wait_clk(HALF);
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        mosi = w[0];
        found = 0;
        prev = bus.io_out[0];
        for (int t = 0; t < 600 && found == 0; t++) begin
            @(negedge clk);
            if (!prev && bus.io_out[0]) found = 1;
            prev = bus.io_out[0];
        end
        check("mid_find_pulse", found, 1);
        len = 1;
        k = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            k++;
            if (k == 27)          sclk = 1'b1;
            if (k == 27 + HALF)   sclk = 1'b0;
            if (k == 27 + 2*HALF) cs = 1'b1;
            if (bus.io_out[0]) len++;
            else break;
        end
        cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        shadow_m[0] = 10;
        check("mid_current_period", len, 64);
        found = 0;
        prev = bus.io_out[0];
        for (int t = 0; t < 300 && found == 0; t++) begin
            @(negedge clk);
            if (!prev && bus.io_out[0]) found = 1;
            prev = bus.io_out[0];
        end
        len = 0;
        if (found == 1) begin
            len = 1;
            for (int t = 0; t < 300; t++) begin
                @(negedge clk);
                if (bus.io_out[0]) len++;
                else break;
            end
        end
        check("mid_next_period", len, 10);

        // Randomised writes (including out-of-range addresses), then readback
        for (int r = 0; r < 12; r++)
            host_write(7'($urandom_range(0, 9)), 8'($urandom_range(0, 255)));
        for (int a = 0; a < 8; a++)
            host_read(7'(a), $sformatf("rand_read%0d", a));
        check_pwm("rand");

        // Reset in the middle of a frame
        cs = 1'b0;
        wait_clk(HALF);
        mosi = 1'b1;
        sclk = 1'b1;
        wait_clk(HALF);
        sclk = 1'b0;
        wait_clk(3);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_io_out", {24'd0, bus.io_out}, 0);
        wait_clk(3);
        cs = 1'b1; mosi = 1'b0;
        rst_n = 1'b1;
        for (int n = 0; n < 7; n++) shadow_m[n] = 0;
        wait_clk(2*HALF);
        host_read(7'd3, "post_reset_ch3");
        check_pwm("post_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
`default_nettype wire
